// File: rtl/ram_bist_16x8_pkg.sv
// ram_bist_pkg: constants and state encoding shared by the 16x8 RAM BIST
// (ram_bist_16x8), its RAM-port interface and its address generator.
//   ADDR_W/DATA_W/DEPTH : RAM geometry (16 words x 8 bits)
//   ERR_W               : width of the mismatch counter (up to 32 reads)
//   bist_state_t        : March-style test sequencer states
package ram_bist_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ERR_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    WR_UP,
    RD_UP_A,
    RD_UP_C,
    WR_DN,
    RD_DN_A,
    RD_DN_C,
    DONE
  } bist_state_t;

  // A test is in progress in every state but the two rest states.
  function automatic logic state_is_busy(input bist_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/ram_bist_16x8_if.sv
// ram_bist_16x8_if: single-port 16x8 RAM connection between the BIST
// (initiator) and the RAM under test.
//   ram_addr  : word address            (master -> slave)
//   ram_wdata : write data              (master -> slave)
//   ram_we    : write enable            (master -> slave)
//   ram_rdata : read data               (slave  -> master)
interface ram_bist_16x8_if;
  import ram_bist_pkg::*;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/ram_bist_16x8_addr_gen.sv
// bist_addr_gen: 4-bit up/down address counter for the RAM BIST.
//   clk, rst : clock, asynchronous active-high reset (counter -> 0)
//   i_clr    : synchronous clear to address 0
//   i_en     : advance one step this cycle
//   i_down   : step direction (1 = descending) and terminal-count select
//   o_addr   : current address
//   o_tc     : terminal address of the selected direction (15 up, 0 down)
module bist_addr_gen
  import ram_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);

  logic [ADDR_W-1:0] r_addr;

  // Wrap-around is intentional: stepping past 15 (up) or 0 (down) lands on
  // the start address of the following phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= i_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/ram_bist_16x8.sv
// ram_bist_16x8: built-in self test for a 16x8 single-port RAM.
// Sequence: write PATTERN ascending, read/verify ascending, write ~PATTERN
// descending, read/verify descending, then a one-cycle done pulse.
// Each read takes two cycles (address, then compare) so the RAM may have
// either a combinational or a 1-cycle registered read port.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : level request, sampled only in IDLE
//   busy      : test running
//   done      : one-cycle completion pulse
//   pass      : result, valid from done until next accepted start
//   fail_addr : address of the first mismatch
//   fail_data : data read at the first mismatch
//   err_cnt   : mismatching reads in the current run
//   ram       : RAM initiator port (ram_bist_16x8_if.master)
// Build option: define BIST_STOP_ON_FAIL_EN to end the run at the first
// mismatch instead of completing all 96 test cycles.
module ram_bist_16x8
  import ram_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic [ERR_W-1:0]     err_cnt,
  ram_bist_16x8_if.master      ram
);

  bist_state_t       r_state;
  bist_state_t       w_state_nxt;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_cnt_down;
  logic [ADDR_W-1:0] w_addr;
  logic              w_tc;
  logic              w_busy;
  logic              w_cmp;
  logic [DATA_W-1:0] w_expect;
  logic              w_mismatch;

  bist_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_down (w_cnt_down),
    .o_addr (w_addr),
    .o_tc   (w_tc)
  );

  assign w_busy     = state_is_busy(r_state);
  assign w_cmp      = (r_state == RD_UP_C) || (r_state == RD_DN_C);
  assign w_expect   = (r_state == RD_DN_C) ? ~PATTERN : PATTERN;
  assign w_mismatch = w_cmp && (ram.ram_rdata != w_expect);

  // Counter stepping: write states advance every cycle; read pairs advance
  // on the compare cycle. At the end of a read phase the counter is held so
  // it already sits on the start address of the following write phase; the
  // write phases wrap naturally onto the start of their read phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_down  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (start) w_state_nxt = WR_UP;
      end
      WR_UP: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = RD_UP_A;
      end
      RD_UP_A: begin
        w_state_nxt = RD_UP_C;
      end
      RD_UP_C: begin
        if (w_tc) begin
          w_state_nxt = WR_DN;
        end else begin
          w_cnt_en    = 1'b1;
          w_state_nxt = RD_UP_A;
        end
      end
      WR_DN: begin
        w_cnt_down = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_tc) w_state_nxt = RD_DN_A;
      end
      RD_DN_A: begin
        w_cnt_down  = 1'b1;
        w_state_nxt = RD_DN_C;
      end
      RD_DN_C: begin
        w_cnt_down = 1'b1;
        if (w_tc) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_en    = 1'b1;
          w_state_nxt = RD_DN_A;
        end
      end
      DONE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (w_mismatch) begin
      w_cnt_en    = 1'b0;
      w_state_nxt = DONE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_pass      <= 1'b0;
        r_err_cnt   <= '0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_mismatch) begin
        if (r_err_cnt == '0) begin
          r_fail_addr <= w_addr;
          r_fail_data <= ram.ram_rdata;
        end
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      // The final compare shares its edge with the DONE entry, so the
      // verdict folds in the current cycle's mismatch.
      if ((w_state_nxt == DONE) && (r_state != DONE)) begin
        r_pass <= (r_err_cnt == '0) && !w_mismatch;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

  assign ram.ram_addr  = w_busy ? w_addr : '0;
  assign ram.ram_we    = (r_state == WR_UP) || (r_state == WR_DN);
  assign ram.ram_wdata = (r_state == WR_UP) ? PATTERN :
                         (r_state == WR_DN) ? ~PATTERN : '0;

endmodule

// File: doc/ram_bist_16x8.md
RAM_BIST_16X8 -- requirements
Module: ram_bist_16x8

Interface
REQ-001 SHALL have parameter PATTERN, default 8'h55, background data pattern; the complement is ~PATTERN.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, level request to begin a test, sampled only in IDLE.
REQ-005 SHALL have port busy, output, 1, high while a test runs.
REQ-006 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-007 SHALL have port pass, output, 1, result, valid from done until next accepted start.
REQ-008 SHALL have port fail_addr, output, 4, address of first mismatch.
REQ-009 SHALL have port fail_data, output, 8, data read at first mismatch.
REQ-010 SHALL have port err_cnt, output, 6, count of mismatching reads in the current run.
REQ-011 SHALL have ports ram_addr (output, 4), ram_wdata (output, 8), ram_we (output, 1) and ram_rdata (input, 8), forming the initiator side of a 16x8 RAM port (addr, data_in, write_enable, data_out).

Function
REQ-012 SHALL implement the states IDLE, WR_UP, RD_UP_A, RD_UP_C, WR_DN, RD_DN_A, RD_DN_C and DONE.
REQ-013 SHALL move from IDLE to WR_UP on the edge sampling start=1, clearing pass, err_cnt, fail_addr and fail_data.
REQ-014 SHALL, in WR_UP, drive ram_we=1 and ram_wdata=PATTERN for one cycle per address, ascending 0..15.
REQ-015 SHALL perform each read in two cycles: A drives ram_addr with ram_we=0; C holds ram_addr and compares ram_rdata at the closing edge, so the block works with both combinational-read and 1-cycle-registered-read RAMs.
REQ-016 SHALL read and verify PATTERN ascending 0..15 (RD_UP), then write ~PATTERN descending 15..0 (WR_DN), then read and verify ~PATTERN descending 15..0 (RD_DN).
REQ-017 SHALL enter DONE after the RD_DN_C cycle of address 0, assert done for exactly that one cycle, then return to IDLE.
REQ-018 SHALL give a fixed latency: with start sampled at edge 0, writes occupy cycles 1-16, RD_UP cycles 17-48, WR_DN cycles 49-64, RD_DN cycles 65-96, and done is high in cycle 97.
REQ-019 SHALL hold busy=1 in every state except IDLE and DONE.
REQ-020 SHALL keep ram_we=0 outside WR_UP and WR_DN.
REQ-021 SHALL, on a mismatch, increment err_cnt and, only if it is the first mismatch of the run, capture fail_addr and fail_data.
REQ-022 SHALL set pass=1 at DONE exactly when err_cnt=0.
REQ-023 SHALL ignore start while busy; if start is held high, the next run begins on the edge after the return to IDLE.
REQ-024 SHALL wrap the address counter without overflow side effects: the terminal address (15 ascending, 0 descending) advances the phase.

Reset
REQ-025 SHALL, on rst assertion, immediately force state IDLE and drive busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, fail_data=0, ram_addr=0, ram_wdata=0 and ram_we=0, including when a run is in progress.
REQ-026 SHALL require a fresh start after rst deassertion; no run resumes.

Configuration
REQ-027 SHALL, with macro BIST_STOP_ON_FAIL_EN defined, abort at the first mismatch: go to DONE on the next edge with pass=0 and err_cnt=1.
REQ-028 SHALL, without BIST_STOP_ON_FAIL_EN, always run all 96 cycles and count every mismatch (maximum 32).

Structure
REQ-029 SHALL take the state enumeration and the constants ADDR_W=4, DATA_W=8 and DEPTH=16 from shared package ram_bist_pkg.
REQ-030 SHALL place the 4-bit up/down address counter with its terminal-count flag in sub-module bist_addr_gen.

Verification
REQ-031 SHALL cover: reset, then start pulse against a fault-free 16x8 RAM -> done in cycle 97, pass=1, err_cnt=0.
REQ-032 SHALL cover: cycle 1 -> ram_addr=0, ram_wdata=8'h55, ram_we=1; cycle 49 -> ram_addr=15, ram_wdata=8'hAA, ram_we=1.
REQ-033 SHALL cover: RAM bit 0 stuck-at-0 at address 5, macro undefined -> pass=0, fail_addr=5, fail_data=8'h54, err_cnt=1, done in cycle 97.
REQ-034 SHALL cover: same fault, BIST_STOP_ON_FAIL_EN defined -> done in cycle 29, pass=0, err_cnt=1.
REQ-035 SHALL cover: start held high throughout -> start re-pulses during busy are ignored, and a second run's first write occurs in cycle 99.
REQ-036 SHALL cover: rst asserted mid-cycle 40 -> ram_we=0 and busy=0 without waiting for a clock edge, pass=0, and the block stays in IDLE until the next start.
